alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_driver_if.sv | 24 ++
 rtl/alu_driver.sv | 122 ++++++++++++
 tb/tb_alu_driver.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_driver_if.sv
// Request/response bus between a client and alu_driver.
// Both channels use valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; the sender holds its payload stable while valid is high.
interface alu_driver_if #(parameter int WIDTH = 16);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_op;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_op
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_op
  );
endinterface

// File: rtl/alu_driver.sv
// Registers one ALU request at a time, captures the combinational ALU result a
// cycle later into a 2-entry in-order response buffer, and counts captures.
module alu_driver #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  alu_driver_if.slave      bus,
  output logic [1:0]       opCode,
  output logic [WIDTH-1:0] inputA,
  output logic [WIDTH-1:0] inputB,
  input  logic [WIDTH-1:0] result,
  output logic [15:0]      op_count,
  output logic             dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             ready;
  logic             hs;
  logic             push;
  logic             pop;

  logic [1:0]       count_q;
  logic [WIDTH-1:0] head_data_q;
  logic [1:0]       head_op_q;
  logic [WIDTH-1:0] tail_data_q;
  logic [1:0]       tail_op_q;
  logic [15:0]      cnt_q;

  always_ff @(posedge clock) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Accepting only with a free slot guarantees room for the capture one cycle later.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    hs      = 1'b0;
    push    = 1'b0;
    pop     = (count_q != 2'd0) && bus.rsp_ready;
    case (state_q)
      IDLE: begin
        ready = (count_q < 2'd2);
        hs    = ready && bus.req_valid;
        if (hs) state_d = ISSUE;
      end
      ISSUE: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      opCode      <= 2'b00;
      inputA      <= '0;
      inputB      <= '0;
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_op_q   <= 2'b00;
      tail_data_q <= '0;
      tail_op_q   <= 2'b00;
      cnt_q       <= 16'd0;
    end else begin
      if (hs) begin
        opCode <= bus.req_op;
        inputA <= bus.req_a;
        inputB <= bus.req_b;
      end
      if (push) cnt_q <= cnt_q + 16'd1;
      // The head register keeps its last value when the buffer drains.
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_data_q <= result;
            head_op_q   <= opCode;
          end else begin
            tail_data_q <= result;
            tail_op_q   <= opCode;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            head_data_q <= tail_data_q;
            head_op_q   <= tail_op_q;
          end
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_data_q <= result;
            head_op_q   <= opCode;
          end else begin
            head_data_q <= tail_data_q;
            head_op_q   <= tail_op_q;
            tail_data_q <= result;
            tail_op_q   <= opCode;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (count_q != 2'd0);
  assign bus.rsp_data  = head_data_q;
  assign bus.rsp_op    = head_op_q;
  assign op_count      = cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: vector table, backpressure, push/pop overlap,
// mid-operation clear and op_count wrap, with a behavioral ALU as result source.
module tb_alu_driver;
  localparam int W = 16;

  logic          clock;
  logic          clear;
  logic [1:0]    opCode;
  logic [W-1:0]  inputA;
  logic [W-1:0]  inputB;
  logic [W-1:0]  result;
  logic [15:0]   op_count;
  logic          dbg_state;

  alu_driver_if #(.WIDTH(W)) bus ();

  alu_driver #(.WIDTH(W)) dut (
    .clock     (clock),
    .clear     (clear),
    .bus       (bus),
    .opCode    (opCode),
    .inputA    (inputA),
    .inputB    (inputB),
    .result    (result),
    .op_count  (op_count),
    .dbg_state (dbg_state)
  );

  // Behavioral ALU; the reserved opcode returns A^B so its capture is observable.
  always_comb begin
    result = '0;
    case (opCode)
      2'b00:   result = inputA + inputB;
      2'b01:   result = inputA - inputB;
      2'b10:   result = ~inputA;
      default: result = inputA ^ inputB;
    endcase
  end

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int              checks   = 0;
  int              failures = 0;
  logic [W+1:0]    exp_q[$];
  logic [15:0]     exp_cnt  = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_head(input string name);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty got 0x%0h expected none", name, bus.rsp_data);
    end else begin
      e = exp_q.pop_front();
      check({name, "_data"}, 32'(bus.rsp_data), 32'(e[W-1:0]));
      check({name, "_op"}, 32'(bus.rsp_op), 32'(e[W+1:W]));
    end
  endtask

  // drivers (all called at a falling edge, return at a falling edge)
  task automatic do_reset();
    clear = 1'b1;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    exp_cnt = 16'd0;
    exp_q.delete();
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    while (!bus.req_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: req_ready got 0 expected 1");
    end
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp);
    exp_q.push_back({op, exp});
    exp_cnt = exp_cnt + 16'd1;
    send(op, a, b);
  endtask

  task automatic recv(input string name);
    int n = 0;
    bus.rsp_ready = 1'b1;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: rsp_valid got 0 expected 1", name);
    end else begin
      check_head(name);
    end
    @(posedge clock);
    @(negedge clock);
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{op: 2'b00, a: 16'h0325, b: 16'h012E, exp: 16'h0453};
    vecs[1] = '{op: 2'b01, a: 16'h0325, b: 16'h012E, exp: 16'h01F7};
    vecs[2] = '{op: 2'b10, a: 16'h012E, b: 16'h5555, exp: 16'hFED1};
    vecs[3] = '{op: 2'b11, a: 16'h1234, b: 16'h00FF, exp: 16'h12CB};
    vecs[4] = '{op: 2'b00, a: 16'hFFFF, b: 16'h0002, exp: 16'h0001};
    vecs[5] = '{op: 2'b01, a: 16'h0000, b: 16'h0001, exp: 16'hFFFF};

    clear         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clock);
    do_reset();

    // reset state
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    check("rst_rsp_op",    32'(bus.rsp_op),    32'd0);
    check("rst_op_count",  32'(op_count),      32'd0);
    check("rst_opcode",    32'(opCode),        32'd0);
    check("rst_inputa",    32'(inputA),        32'd0);
    check("rst_inputb",    32'(inputB),        32'd0);
    check("rst_state",     32'(dbg_state),     32'd0);

    // vector table: single request, latency, result and operand hold
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      check("vec_opcode", 32'(opCode), 32'(vecs[i].op));
      check("vec_inputa", 32'(inputA), 32'(vecs[i].a));
      check("vec_inputb", 32'(inputB), 32'(vecs[i].b));
      check("vec_issue_state", 32'(dbg_state), 32'd1);
      check("vec_issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clock);
      check("vec_lat_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("vec_lat_state", 32'(dbg_state), 32'd0);
      recv("vec");
      check("vec_hold_inputb", 32'(inputB), 32'(vecs[i].b));
      check("vec_op_count", 32'(op_count), 32'(exp_cnt));
    end

    // backpressure: two buffered, third blocked until a pop
    issue(2'b01, 16'h0325, 16'h012E, 16'h01F7);
    issue(2'b10, 16'h012E, 16'h0000, 16'hFED1);
    @(negedge clock);
    check("bp_full_ready", 32'(bus.req_ready), 32'd0);
    exp_q.push_back({2'b00, 16'h0453});
    exp_cnt = exp_cnt + 16'd1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 16'h0325;
    bus.req_b     = 16'h012E;
    repeat (3) @(negedge clock);
    check("bp_blocked_ready", 32'(bus.req_ready), 32'd0);
    check("bp_blocked_count", 32'(op_count), 32'(exp_cnt - 16'd1));
    check("bp_blocked_opcode", 32'(opCode), 32'b10);
    recv("bp_first");
    check("bp_after_pop_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("bp_third_inputa", 32'(inputA), 32'h0325);
    recv("bp_second");
    recv("bp_third");
    check("bp_op_count", 32'(op_count), 32'(exp_cnt));

    // simultaneous push and pop at occupancy 1
    issue(2'b00, 16'h1000, 16'h0234, 16'h1234);
    @(negedge clock);
    check("pp_occ1_valid", 32'(bus.rsp_valid), 32'd1);
    check_head("pp_first");
    exp_q.push_back({2'b01, 16'h0EEF});
    exp_cnt = exp_cnt + 16'd1;
    send(2'b01, 16'h1000, 16'h0111);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    check("pp_occ_kept", 32'(bus.rsp_valid), 32'd1);
    check_head("pp_second");
    @(negedge clock);
    check("pp_drained", 32'(bus.rsp_valid), 32'd0);
    @(negedge clock);
    check("pp_empty_pop_valid", 32'(bus.rsp_valid), 32'd0);
    check("pp_empty_hold_data", 32'(bus.rsp_data), 32'h0EEF);
    check("pp_empty_hold_op", 32'(bus.rsp_op), 32'b01);
    bus.rsp_ready = 1'b0;
    check("pp_op_count", 32'(op_count), 32'(exp_cnt));

    // clear during ISSUE aborts the capture
    send(2'b00, 16'h0001, 16'h0001);
    check("rc_in_issue", 32'(dbg_state), 32'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    exp_cnt = 16'd0;
    check("rc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rc_op_count",  32'(op_count),      32'd0);
    check("rc_req_ready", 32'(bus.req_ready), 32'd1);
    check("rc_state",     32'(dbg_state),     32'd0);
    check("rc_inputa",    32'(inputA),        32'd0);
    @(negedge clock);
    check("rc_no_late_push", 32'(bus.rsp_valid), 32'd0);

    // op_count wrap from a preset near the top
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    exp_cnt = 16'hFFFE;
    issue(2'b00, 16'h0002, 16'h0003, 16'h0005);
    recv("wrap_a");
    check("wrap_ffff", 32'(op_count), 32'(exp_cnt));
    issue(2'b10, 16'h0000, 16'h0000, 16'hFFFF);
    recv("wrap_b");
    check("wrap_zero", 32'(op_count), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
